// File: rtl/mmcsr_axil_pkg.sv
// Shared types and helpers for the AXI4-Lite CSR responder.
// Latency: n/a (package only).
// Backpressure: n/a.
package mmcsr_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [31:0] csr_word_t;

    // Merge new data into an existing word, one byte lane per strobe bit.
    function automatic csr_word_t apply_wstrb(input csr_word_t old,
                                              input csr_word_t data,
                                              input logic [3:0] strb);
        csr_word_t mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/mmcsr_axil_slave_if.sv
// AXI4-Lite link bundle between interconnect master and CSR responder.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on all five channels.
interface mmcsr_axil_slave_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

endinterface

// File: rtl/mmcsr_axil_hold_buf.sv
// One-entry holding register with pass-through when empty.
// Latency: 0 (an incoming beat is visible on out_* the same cycle).
// Backpressure: in_rdy_o low while holding an entry or in reset.
module mmcsr_axil_hold_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    output logic         in_rdy_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    input  logic         pop_i
);

    logic         live_q;
    logic         full_q;
    logic [W-1:0] dat_q;

    // live_q keeps ready low until the first edge after reset release.
    assign in_rdy_o  = live_q && !full_q;
    assign out_vld_o = full_q || (in_vld_i && in_rdy_o);
    assign out_dat_o = full_q ? dat_q : in_dat_i;

    // Capture a beat that is not consumed in the cycle it arrives; drop on pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q <= 1'b0;
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (pop_i) begin
                full_q <= 1'b0;
            end else if (in_vld_i && in_rdy_o) begin
                full_q <= 1'b1;
                dat_q  <= in_dat_i;
            end
        end
    end

endmodule

// File: rtl/mmcsr_axil_slave.sv
// AXI4-Lite responder for a bank of 32-bit CSRs with RW and RO words.
// Latency: B one cycle after the later of AW/W handshake; R one cycle after AR.
// Backpressure: pending B stalls commits (one AW and one W buffered); ARREADY = !RVALID || RREADY.
module mmcsr_axil_slave
    import mmcsr_axil_pkg::*;
#(
    parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned         NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = 8'hC0
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    mmcsr_axil_slave_if.slave        s_axi,
    output logic [NUM_REGS*32-1:0]   csr_q,
    output logic [NUM_REGS-1:0]      csr_wr_pulse,
    input  logic [NUM_REGS*32-1:0]   ro_data
);

    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned REG_IW = $clog2(NUM_REGS);
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    csr_word_t regs_q [NUM_REGS];
    csr_word_t regs_d [NUM_REGS];
    csr_word_t ro_words [NUM_REGS];

    logic [NUM_REGS-1:0] pulse_q, pulse_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    csr_word_t           rdata_q, rdata_d;
    logic                live_q;

    // ---------------- write path ----------------
    logic                                aw_vld, w_vld, commit;
    logic [IDX_W-1:0]                    aw_idx;
    logic [C_S_AXI_DATA_WIDTH+STRB_W-1:0] w_dat;
    csr_word_t                           wdata;
    logic [STRB_W-1:0]                   wstrb;
    logic [REG_IW-1:0]                   aw_reg;
    logic                                aw_in_range, aw_wr_en;

    // Only the word index is kept; byte offset bits never affect decode.
    mmcsr_axil_hold_buf #(.W(IDX_W)) u_aw_buf (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .in_vld_i  (s_axi.S_AXI_AWVALID),
        .in_dat_i  (s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .in_rdy_o  (s_axi.S_AXI_AWREADY),
        .out_vld_o (aw_vld),
        .out_dat_o (aw_idx),
        .pop_i     (commit)
    );

    mmcsr_axil_hold_buf #(.W(C_S_AXI_DATA_WIDTH + STRB_W)) u_w_buf (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .in_vld_i  (s_axi.S_AXI_WVALID),
        .in_dat_i  ({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
        .in_rdy_o  (s_axi.S_AXI_WREADY),
        .out_vld_o (w_vld),
        .out_dat_o (w_dat),
        .pop_i     (commit)
    );

    assign wdata       = w_dat[C_S_AXI_DATA_WIDTH-1:0];
    assign wstrb       = w_dat[C_S_AXI_DATA_WIDTH +: STRB_W];
    assign commit      = aw_vld && w_vld && (!bvalid_q || s_axi.S_AXI_BREADY);
    assign aw_in_range = (32'(aw_idx) < NUM_REGS);
    assign aw_reg      = aw_idx[REG_IW-1:0];
    assign aw_wr_en    = commit && aw_in_range && !RO_MASK[aw_reg];

    // Commit updates the addressed RW word and loads a fresh B response.
    always_comb begin
        regs_d   = regs_q;
        pulse_d  = '0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            if (aw_wr_en) begin
                regs_d[aw_reg]  = apply_wstrb(regs_q[aw_reg], wdata, wstrb);
                pulse_d[aw_reg] = 1'b1;
            end
        end else if (s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // ---------------- read path ----------------
    logic [IDX_W-1:0]  ar_idx;
    logic [REG_IW-1:0] ar_reg;
    logic              ar_in_range, arready, ar_hs;

    assign ar_idx      = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_reg      = ar_idx[REG_IW-1:0];
    assign ar_in_range = (32'(ar_idx) < NUM_REGS);
    assign arready     = live_q && (!rvalid_q || s_axi.S_AXI_RREADY);
    assign ar_hs       = s_axi.S_AXI_ARVALID && arready;

    // Read sees regs_q, so a same-edge write commit returns the old value.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            if (!ar_in_range) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else if (RO_MASK[ar_reg]) begin
                rdata_d = ro_words[ar_reg];
            end else begin
                rdata_d = regs_q[ar_reg];
            end
        end else if (s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // All state, including pending responses, clears asynchronously.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q   <= '{default: '0};
            pulse_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            live_q   <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        assign csr_q[32*i +: 32] = regs_q[i];
        assign ro_words[i]       = ro_data[32*i +: 32];
    end

    assign csr_wr_pulse        = pulse_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
